dmem_lsu: RTL and testbench

//  Load/store unit between the execute stage and the word-only data memory (dmemo).

---
 rtl/dmem_lsu_pkg.sv | 44 ++++
 rtl/dmem_lane_mux.sv | 52 +++++
 rtl/dmem_lsu.sv | 175 +++++++++++++++++
 tb/tb_dmem_lsu.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM encoding,
// and the small helpers for access size and alignment.
package dmem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LD_RD,
    S_LD_CAP,
    S_ST_WR,
    S_RMW_RD,
    S_RMW_MRG,
    S_RMW_WR,
    S_ERR,
    S_RESP
  } state_t;

  // The reserved code 11 is folded into word so that nothing downstream
  // ever sees it.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_WORD : sz;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b0;
    endcase
  endfunction

  // Clears the low address bits that would make the access misaligned.
  function automatic logic [31:0] align_addr(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      SZ_HALF: return {a[31:1], 1'b0};
      SZ_WORD: return {a[31:2], 2'b00};
      default: return a;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_mux.sv
// Byte/half lane steering around one memory word: extracts and extends
// load data, and merges store data into the word read back for RMW.
module dmem_lane_mux
  import dmem_lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic [31:0] merged
);

  logic [4:0]  off;
  logic [31:0] shifted;
  logic [31:0] mask;

  // Bit offset of the addressed lane, shifted extract, extension and merge.
  // In big-endian mode byte k sits at bits [31-8k -: 8], so the offset is
  // mirrored; for a byte, 3-k equals ~k on two bits.
  always_comb begin
    off       = 5'd0;
    mask      = 32'hFFFF_FFFF;
    shifted   = word;
    rdata_ext = word;
    case (size)
      SZ_BYTE: off = BIG_ENDIAN ? {~addr_lo, 3'b000} : {addr_lo, 3'b000};
      SZ_HALF: off = BIG_ENDIAN ? {~addr_lo[1], 4'b0000} : {addr_lo[1], 4'b0000};
      default: off = 5'd0;
    endcase
    shifted = word >> off;
    case (size)
      SZ_BYTE: begin
        rdata_ext = {{24{sext & shifted[7]}}, shifted[7:0]};
        mask      = 32'h0000_00FF << off;
      end
      SZ_HALF: begin
        rdata_ext = {{16{sext & shifted[15]}}, shifted[15:0]};
        mask      = 32'h0000_FFFF << off;
      end
      default: begin
        rdata_ext = shifted;
        mask      = 32'hFFFF_FFFF;
      end
    endcase
    merged = (word & ~mask) | ((wdata << off) & mask);
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of the word-only data memory. Sub-word stores
// are done as read-merge-write; misaligned requests never reach memory.
//
//  state     | meaning
//  ----------+----------------------------------------------------
//  S_IDLE    | ready for a request; memory address set on accept
//  S_LD_RD   | load read cycle
//  S_LD_CAP  | memory data valid; extract/extend into resp_rdata
//  S_ST_WR   | full-word write cycle
//  S_RMW_RD  | read cycle of a byte/half store
//  S_RMW_MRG | merge store lanes into read word, stage the write
//  S_RMW_WR  | merged word write cycle
//  S_ERR     | misaligned request, no memory access
//  S_RESP    | one-cycle response pulse
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN      = 1'b0,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign_err,
  output logic        mem_we,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state, state_nxt;
  logic        accept, err_go;
  logic [1:0]  size_n;
  logic [31:0] addr_fix;

  logic        lat_signed;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr, lat_wdata;

  logic        mem_we_d, misalign_err_d;
  logic [31:0] mem_raddr_d, mem_waddr_d, mem_wdata_d, resp_rdata_d;
  logic [31:0] lane_rdata, lane_merged;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign accept     = req_valid & req_ready;
  assign size_n     = norm_size(req_size);
  assign err_go     = is_misaligned(size_n, req_addr[1:0]) && ERR_ON_MISALIGN;
  assign addr_fix   = align_addr(size_n, req_addr);

  dmem_lane_mux #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .word      (mem_rdata),
    .addr_lo   (lat_addr[1:0]),
    .size      (lat_size),
    .sext      (lat_signed),
    .wdata     (lat_wdata),
    .rdata_ext (lane_rdata),
    .merged    (lane_merged)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (err_go)                 state_nxt = S_ERR;
          else if (!req_we)           state_nxt = S_LD_RD;
          else if (size_n == SZ_WORD) state_nxt = S_ST_WR;
          else                        state_nxt = S_RMW_RD;
        end
      end
      S_LD_RD:   state_nxt = S_LD_CAP;
      S_LD_CAP:  state_nxt = S_RESP;
      S_ST_WR:   state_nxt = S_RESP;
      S_RMW_RD:  state_nxt = S_RMW_MRG;
      S_RMW_MRG: state_nxt = S_RMW_WR;
      S_RMW_WR:  state_nxt = S_RESP;
      S_ERR:     state_nxt = S_RESP;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered memory and response outputs; memory
  // signals are set up one cycle ahead so they are valid in the named state.
  always_comb begin
    mem_we_d       = 1'b0;
    mem_raddr_d    = mem_raddr;
    mem_waddr_d    = mem_waddr;
    mem_wdata_d    = mem_wdata;
    resp_rdata_d   = resp_rdata;
    misalign_err_d = misalign_err;
    case (state)
      S_IDLE: begin
        if (accept && !err_go) begin
          if (!req_we || size_n != SZ_WORD) begin
            mem_raddr_d = {addr_fix[31:2], 2'b00};
          end else begin
            mem_we_d    = 1'b1;
            mem_waddr_d = {addr_fix[31:2], 2'b00};
            mem_wdata_d = req_wdata;
          end
        end
      end
      S_LD_CAP: begin
        resp_rdata_d   = lane_rdata;
        misalign_err_d = 1'b0;
      end
      S_RMW_MRG: begin
        mem_we_d    = 1'b1;
        mem_waddr_d = {lat_addr[31:2], 2'b00};
        mem_wdata_d = lane_merged;
      end
      S_ST_WR, S_RMW_WR: begin
        resp_rdata_d   = 32'd0;
        misalign_err_d = 1'b0;
      end
      S_ERR: begin
        resp_rdata_d   = 32'd0;
        misalign_err_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers; reset drops mem_we immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we       <= 1'b0;
      mem_raddr    <= 32'd0;
      mem_waddr    <= 32'd0;
      mem_wdata    <= 32'd0;
      resp_rdata   <= 32'd0;
      misalign_err <= 1'b0;
    end else begin
      mem_we       <= mem_we_d;
      mem_raddr    <= mem_raddr_d;
      mem_waddr    <= mem_waddr_d;
      mem_wdata    <= mem_wdata_d;
      resp_rdata   <= resp_rdata_d;
      misalign_err <= misalign_err_d;
    end
  end

  // Request capture on accept; the address is stored already aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_signed <= 1'b0;
      lat_size   <= SZ_BYTE;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
    end else if (accept) begin
      lat_signed <= req_signed;
      lat_size   <= size_n;
      lat_addr   <= addr_fix;
      lat_wdata  <= req_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a small word-only memory model.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, misalign_err, mem_we;
  logic [31:0] resp_rdata, mem_raddr, mem_waddr, mem_wdata, rdata_a;

  logic        b_valid = 1'b0, b_we = 1'b0, b_signed = 1'b0;
  logic [1:0]  b_size = 2'b00;
  logic [31:0] b_addr = 32'd0, b_wdata = 32'd0;
  logic        b_ready, b_resp_valid, b_err, b_mem_we;
  logic [31:0] b_rdata, raddr_b, waddr_b, wdata_b, rdata_b;

  logic        preload = 1'b1;
  logic [31:0] mem [0:3];

  int vectors = 0;
  int miscompares = 0;

  int          r_lat, r_wecnt, r_wecyc;
  logic [31:0] r_waddr, r_wdata, r_rdata, r_raddr;
  logic        r_err;

  dmem_lsu #(.BIG_ENDIAN(1'b0), .ERR_ON_MISALIGN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .misalign_err(misalign_err), .mem_we(mem_we), .mem_raddr(mem_raddr),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_rdata(rdata_a)
  );

  dmem_lsu #(.BIG_ENDIAN(1'b0), .ERR_ON_MISALIGN(1'b0)) u_dut_na (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_size(b_size), .req_signed(b_signed), .req_addr(b_addr),
    .req_wdata(b_wdata), .resp_valid(b_resp_valid), .resp_rdata(b_rdata),
    .misalign_err(b_err), .mem_we(b_mem_we), .mem_raddr(raddr_b),
    .mem_waddr(waddr_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b)
  );

  // Memory model: write port from the main DUT, one-cycle read latency.
  always @(posedge clk) begin
    if (preload) begin
      mem[0] <= 32'h8899_AABB;
      mem[1] <= 32'h0000_0000;
      mem[2] <= 32'h0000_0000;
      mem[3] <= 32'h0000_0000;
    end else if (mem_we) begin
      mem[mem_waddr[3:2]] <= mem_wdata;
    end
    rdata_a <= mem[mem_raddr[3:2]];
    rdata_b <= mem[raddr_b[3:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on the main DUT; records latency, writes and response.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    r_lat = -1; r_wecnt = 0; r_wecyc = -1; r_raddr = mem_raddr;
    r_waddr = 32'hx; r_wdata = 32'hx; r_rdata = 32'hx; r_err = 1'bx;
    for (int c = 1; c <= 10; c++) begin
      if (mem_we) begin
        r_wecnt++; r_wecyc = c; r_waddr = mem_waddr; r_wdata = mem_wdata;
      end
      if (resp_valid) begin
        r_lat = c; r_rdata = resp_rdata; r_err = misalign_err;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] e2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(misalign_err), 32'd0);
    chk("rst_raddr", mem_raddr, 32'd0);
    chk("rst_waddr", mem_waddr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_b_out", {b_mem_we, waddr_b[30:0]} | wdata_b, 32'd0);
    preload = 1'b0;
    rst_n = 1'b1;

    run_req(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    chk("lw0_lat", 32'(r_lat), 32'd3);
    chk("lw0_rdata", r_rdata, 32'h8899_AABB);
    chk("lw0_err", 32'(r_err), 32'd0);
    chk("lw0_we", 32'(r_wecnt), 32'd0);
    chk("lw0_raddr", r_raddr, 32'h0);

    run_req(1'b0, SZ_BYTE, 1'b1, 32'h3, 32'h0);
    chk("lb3_rdata", r_rdata, 32'hFFFF_FF88);
    chk("lb3_lat", 32'(r_lat), 32'd3);

    run_req(1'b0, SZ_BYTE, 1'b0, 32'h3, 32'h0);
    chk("lbu3_rdata", r_rdata, 32'h0000_0088);

    run_req(1'b0, SZ_HALF, 1'b0, 32'h2, 32'h0);
    chk("lhu2_rdata", r_rdata, 32'h0000_8899);
    chk("lhu2_raddr", r_raddr, 32'h0);

    run_req(1'b0, SZ_HALF, 1'b1, 32'h1, 32'h0);
    chk("lh1_lat", 32'(r_lat), 32'd2);
    chk("lh1_err", 32'(r_err), 32'd1);
    chk("lh1_rdata", r_rdata, 32'h0);
    chk("lh1_we", 32'(r_wecnt), 32'd0);

    // Same misaligned half load on the force-align instance.
    @(posedge clk); #1;
    b_valid = 1'b1; b_we = 1'b0; b_size = SZ_HALF; b_signed = 1'b1; b_addr = 32'h1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    chk("na_raddr", raddr_b, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("na_resp", 32'(b_resp_valid), 32'd1);
    chk("na_rdata", b_rdata, 32'hFFFF_AABB);
    chk("na_err", 32'(b_err), 32'd0);
    chk("na_we", 32'(b_mem_we), 32'd0);

    run_req(1'b1, SZ_BYTE, 1'b0, 32'h1, 32'h0000_00CC);
    chk("sb1_lat", 32'(r_lat), 32'd4);
    chk("sb1_wecnt", 32'(r_wecnt), 32'd1);
    chk("sb1_wecyc", 32'(r_wecyc), 32'd3);
    chk("sb1_waddr", r_waddr, 32'h0);
    chk("sb1_wdata", r_wdata, 32'h8899_CCBB);
    chk("sb1_mem0", mem[0], 32'h8899_CCBB);
    chk("sb1_rdata", r_rdata, 32'h0);

    run_req(1'b1, SZ_HALF, 1'b0, 32'h6, 32'hFFFF_1234);
    chk("sh6_waddr", r_waddr, 32'h4);
    chk("sh6_mem1", mem[1], 32'h1234_0000);

    run_req(1'b0, SZ_HALF, 1'b1, 32'h6, 32'h0);
    chk("lh6_rdata", r_rdata, 32'h0000_1234);

    run_req(1'b0, SZ_BYTE, 1'b0, 32'h2, 32'h0);
    chk("lbu2_rdata", r_rdata, 32'h0000_0099);

    run_req(1'b1, SZ_WORD, 1'b0, 32'h4, 32'hDEAD_BEEF);
    chk("sw4_lat", 32'(r_lat), 32'd2);
    chk("sw4_wecyc", 32'(r_wecyc), 32'd1);
    chk("sw4_wdata", r_wdata, 32'hDEAD_BEEF);
    chk("sw4_mem1", mem[1], 32'hDEAD_BEEF);

    run_req(1'b0, 2'b11, 1'b1, 32'h4, 32'h0);
    chk("l11_lat", 32'(r_lat), 32'd3);
    chk("l11_rdata", r_rdata, 32'hDEAD_BEEF);

    run_req(1'b1, 2'b11, 1'b0, 32'h8, 32'hCAFE_F00D);
    chk("s11_lat", 32'(r_lat), 32'd2);
    chk("s11_mem2", mem[2], 32'hCAFE_F00D);

    run_req(1'b1, SZ_HALF, 1'b0, 32'h3, 32'h0000_7777);
    chk("sh3_err", 32'(r_err), 32'd1);
    chk("sh3_we", 32'(r_wecnt), 32'd0);
    chk("sh3_mem0", mem[0], 32'h8899_CCBB);

    // Back-to-back: valid held; second accept only in the cycle after RESP.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_signed = 1'b0; req_addr = 32'h0;
    @(posedge clk); #1;
    for (int c = 1; c <= 7; c++) begin
      e2 = (c == 4) ? 2'b10 : ((c == 3 || c == 7) ? 2'b01 : 2'b00);
      chk($sformatf("b2b_c%0d", c), {30'd0, req_ready, resp_valid}, {30'd0, e2});
      if (c == 5) req_valid = 1'b0;
      @(posedge clk); #1;
    end

    // Reset asserted while sb 0x0 is in its read cycle.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_addr = 32'h0; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rmw_busy", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rmwrst_we", 32'(mem_we), 32'd0);
    chk("rmwrst_ready", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rmwrst_mem0", mem[0], 32'h8899_CCBB);

    run_req(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    chk("post_rst_lw", r_rdata, 32'h8899_CCBB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
